// File: rtl/dma_bus_master_fsm.sv
// 68030 bus-master sequencer that moves longwords between the transfer FIFO and memory.
// Define DMA_WDOG_EN to abort a cycle when DSACK_ does not arrive within WDOG_CYCLES clocks.
module dma_bus_master_fsm #(
  parameter int BURST_LEN   = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       CLR_DMAENA,
  input  logic       DMAENA,
  input  logic       DMADIR,
  input  logic       FIFO_FULL,
  input  logic       FIFO_EMPTY,
  input  logic       BG_,
  input  logic       BGACK_I_,
  input  logic [1:0] DSACK_,
  input  logic       BERR_,
  output logic       BR_,
  output logic       BGACK_,
  output logic       AS_,
  output logic       DS_,
  output logic       RW,
  output logic       DOE,
  output logic       FIFO_WR,
  output logic       FIFO_RD,
  output logic       INCADR,
  output logic       DMA_ERR
);

  typedef enum logic [2:0] {
    IDLE, REQ, OWN, S_AS, S_WAIT, S_TERM, S_GAP, RELEASE
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       svc;
  logic       dsack_ok;
  logic       bus_fault;
  logic       wd_expired;

  assign svc       = DMAENA & ~err_q & (DMADIR ? ~FIFO_FULL : ~FIFO_EMPTY);
  assign dsack_ok  = (DSACK_ == 2'b00);
  // Only 32-bit ports are supported, so a byte/word acknowledge is a fault.
  assign bus_fault = ~BERR_ | (DSACK_ == 2'b01) | (DSACK_ == 2'b10);

`ifdef DMA_WDOG_EN
  localparam int             WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = '0;
    if (state_q == S_WAIT) wd_d = wd_q + 1'b1;
  end

  assign wd_expired = (state_q == S_WAIT) && (wd_q == WD_LAST);

  always_ff @(posedge CLK or posedge CLR_DMAENA) begin
    if (CLR_DMAENA) wd_q <= '0;
    else            wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge CLK or posedge CLR_DMAENA) begin
    if (CLR_DMAENA) begin
      state_q <= IDLE;
      burst_q <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state so a reset drops every strobe without waiting for CLK.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    dir_d   = dir_q;
    err_d   = err_q;
    BR_     = 1'b1;
    BGACK_  = 1'b1;
    AS_     = 1'b1;
    DS_     = 1'b1;
    RW      = 1'b1;
    DOE     = 1'b0;
    FIFO_WR = 1'b0;
    FIFO_RD = 1'b0;
    INCADR  = 1'b0;

    case (state_q)
      IDLE: begin
        if (svc) state_d = REQ;
      end
      REQ: begin
        BR_ = 1'b0;
        if (!svc)                  state_d = IDLE;
        else if (!BG_ && BGACK_I_) state_d = OWN;
      end
      OWN: begin
        BGACK_  = 1'b0;
        burst_d = '0;
        state_d = S_AS;
      end
      S_AS: begin
        // Direction is captured here and held until the cycle ends.
        BGACK_  = 1'b0;
        AS_     = 1'b0;
        RW      = DMADIR;
        DOE     = ~DMADIR;
        DS_     = ~DMADIR;
        dir_d   = DMADIR;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        BGACK_ = 1'b0;
        AS_    = 1'b0;
        DS_    = 1'b0;
        RW     = dir_q;
        DOE    = ~dir_q;
        if (bus_fault || wd_expired) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (dsack_ok) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        BGACK_  = 1'b0;
        RW      = dir_q;
        INCADR  = 1'b1;
        FIFO_WR = dir_q;
        FIFO_RD = ~dir_q;
        burst_d = burst_q + 4'd1;
        state_d = S_GAP;
      end
      S_GAP: begin
        // FIFO flags have settled after the strobe; decide on another cycle.
        BGACK_ = 1'b0;
        if ((burst_q == BURST_MAX) || !svc) state_d = RELEASE;
        else                                state_d = S_AS;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign DMA_ERR = err_q;

endmodule
